// File: rtl/uart_echo_loop_if.sv
// Serial line bundle between a host UART and the echo loop.
// The host drives rx and observes tx; the echo loop does the reverse.
interface uart_echo_loop_if;
    logic rx;
    logic tx;

    modport master (output rx, input tx);
    modport slave  (input rx, output tx);
endinterface

// File: rtl/uart_echo_loop.sv
// 8N1 UART loopback: receives frames on rx and retransmits every correctly
// framed byte on tx, with a one-byte holding register between the two sides.
module uart_echo_loop #(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600
) (
    input  logic            clk,
    input  logic            rst,
    uart_echo_loop_if.slave ser
);
    localparam int BIT_CYCLES  = SYSTEM_CLOCK / BAUD_RATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    logic             rx_meta_r;
    logic             rx_sync_r;
    rx_state_t        rx_state_r;
    rx_state_t        rx_state_next_s;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [CNT_W-1:0] rx_cnt_next_s;
    logic [2:0]       rx_bits_r;
    logic [2:0]       rx_bits_next_s;
    logic [7:0]       rx_shift_r;
    logic [7:0]       rx_shift_next_s;
    logic             rx_valid_s;

    tx_state_t        tx_state_r;
    tx_state_t        tx_state_next_s;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [CNT_W-1:0] tx_cnt_next_s;
    logic [2:0]       tx_bits_r;
    logic [2:0]       tx_bits_next_s;
    logic [7:0]       tx_shift_r;
    logic [7:0]       tx_shift_next_s;
    logic             tx_r;
    logic             tx_next_s;
    logic             tx_done_s;
    logic             tx_free_s;

    logic             load_s;
    logic [7:0]       load_data_s;
    logic             hold_full_r;
    logic             hold_full_next_s;
    logic [7:0]       hold_data_r;
    logic [7:0]       hold_data_next_s;

    assign ser.tx = tx_r;

    // Two-flop synchroniser for the asynchronous rx line, idle-high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= ser.rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bits_r  <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_state_r <= rx_state_next_s;
            rx_cnt_r   <= rx_cnt_next_s;
            rx_bits_r  <= rx_bits_next_s;
            rx_shift_r <= rx_shift_next_s;
        end
    end

    // Receiver next-state: half-bit start qualification, then centre sampling.
    always_comb begin
        rx_state_next_s = rx_state_r;
        rx_cnt_next_s   = rx_cnt_r;
        rx_bits_next_s  = rx_bits_r;
        rx_shift_next_s = rx_shift_r;
        rx_valid_s      = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_next_s = '0;
                if (!rx_sync_r) begin
                    rx_state_next_s = RX_START;
                end else begin
                    rx_state_next_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_next_s  = '0;
                    rx_bits_next_s = 3'd0;
                    if (!rx_sync_r) begin
                        rx_state_next_s = RX_DATA;
                    end else begin
                        rx_state_next_s = RX_IDLE;
                    end
                end else begin
                    rx_cnt_next_s = rx_cnt_r + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_next_s   = '0;
                    rx_shift_next_s = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bits_r == 3'd7) begin
                        rx_state_next_s = RX_STOP;
                    end else begin
                        rx_bits_next_s = rx_bits_r + 1'b1;
                    end
                end else begin
                    rx_cnt_next_s = rx_cnt_r + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_next_s = '0;
                    if (rx_sync_r) begin
                        rx_valid_s      = 1'b1;
                        rx_state_next_s = RX_IDLE;
                    end else begin
                        rx_state_next_s = RX_WAIT_IDLE;
                    end
                end else begin
                    rx_cnt_next_s = rx_cnt_r + 1'b1;
                end
            end
            RX_WAIT_IDLE: begin
                rx_cnt_next_s = '0;
                if (rx_sync_r) begin
                    rx_state_next_s = RX_IDLE;
                end else begin
                    rx_state_next_s = RX_WAIT_IDLE;
                end
            end
            default: begin
                rx_state_next_s = RX_IDLE;
                rx_cnt_next_s   = '0;
            end
        endcase
    end

    // The transmitter can accept a byte when idle or in the last stop-bit cycle,
    // so continuous input frames are retransmitted without accumulating slip.
    assign tx_done_s = (tx_state_r == TX_STOP) && (tx_cnt_r == BIT_LAST);
    assign tx_free_s = (tx_state_r == TX_IDLE) || tx_done_s;

    // Echo routing: held byte has priority, a new byte refills the holder.
    always_comb begin
        load_s           = 1'b0;
        load_data_s      = hold_data_r;
        hold_full_next_s = hold_full_r;
        hold_data_next_s = hold_data_r;
        if (tx_free_s && hold_full_r) begin
            load_s      = 1'b1;
            load_data_s = hold_data_r;
            if (rx_valid_s) begin
                hold_data_next_s = rx_shift_r;
            end else begin
                hold_full_next_s = 1'b0;
            end
        end else if (tx_free_s && rx_valid_s) begin
            load_s      = 1'b1;
            load_data_s = rx_shift_r;
        end else if (rx_valid_s && !hold_full_r) begin
            hold_data_next_s = rx_shift_r;
            hold_full_next_s = 1'b1;
        end else begin
            hold_full_next_s = hold_full_r;
        end
    end

    // Holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full_r <= 1'b0;
            hold_data_r <= 8'h00;
        end else begin
            hold_full_r <= hold_full_next_s;
            hold_data_r <= hold_data_next_s;
        end
    end

    // Transmitter state, datapath and registered line output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_bits_r  <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_r       <= 1'b1;
        end else begin
            tx_state_r <= tx_state_next_s;
            tx_cnt_r   <= tx_cnt_next_s;
            tx_bits_r  <= tx_bits_next_s;
            tx_shift_r <= tx_shift_next_s;
            tx_r       <= tx_next_s;
        end
    end

    // Transmitter next-state; tx_next_s is the line level for the coming cycle.
    always_comb begin
        tx_state_next_s = tx_state_r;
        tx_cnt_next_s   = tx_cnt_r;
        tx_bits_next_s  = tx_bits_r;
        tx_shift_next_s = tx_shift_r;
        tx_next_s       = tx_r;
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_next_s = '0;
                if (load_s) begin
                    tx_state_next_s = TX_START;
                    tx_shift_next_s = load_data_s;
                    tx_next_s       = 1'b0;
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_next_s = TX_DATA;
                    tx_cnt_next_s   = '0;
                    tx_bits_next_s  = 3'd0;
                    tx_next_s       = tx_shift_r[0];
                end else begin
                    tx_cnt_next_s = tx_cnt_r + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_next_s = '0;
                    if (tx_bits_r == 3'd7) begin
                        tx_state_next_s = TX_STOP;
                        tx_next_s       = 1'b1;
                    end else begin
                        tx_bits_next_s  = tx_bits_r + 1'b1;
                        tx_shift_next_s = {1'b0, tx_shift_r[7:1]};
                        tx_next_s       = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_next_s = tx_cnt_r + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_next_s = '0;
                    if (load_s) begin
                        tx_state_next_s = TX_START;
                        tx_shift_next_s = load_data_s;
                        tx_next_s       = 1'b0;
                    end else begin
                        tx_state_next_s = TX_IDLE;
                        tx_next_s       = 1'b1;
                    end
                end else begin
                    tx_cnt_next_s = tx_cnt_r + 1'b1;
                end
            end
            default: begin
                tx_state_next_s = TX_IDLE;
                tx_cnt_next_s   = '0;
                tx_next_s       = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_echo_loop.sv
// Directed bench for uart_echo_loop: drives 8N1 frames on rx and decodes the
// echoed frames on tx with an independent line monitor.
module tb_uart_echo_loop;
    localparam int SYS_CLK  = 32000000;
    localparam int BAUD     = 320000;
    localparam int BIT      = SYS_CLK / BAUD;
    localparam int HALF     = BIT / 2;
    localparam int STOP_CTR = 9 * BIT + HALF;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int         frames_total = 0;
    int         aborted = 0;
    int         mon_fall[$];
    int         mon_low[$];
    logic [9:0] mon_lv[$];

    uart_echo_loop_if ser ();

    uart_echo_loop #(.SYSTEM_CLOCK(SYS_CLK), .BAUD_RATE(BAUD)) dut (
        .clk(clk),
        .rst(rst),
        .ser(ser)
    );

    always #16 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: on a falling tx edge, samples the ten bit centres and
    // records the start-of-frame cycle and the length of the first low run.
    initial begin : monitor
        int f;
        int rise;
        bit ok;
        bit risen;
        logic [9:0] lv;
        forever begin
            @(negedge clk);
            if (!rst && ser.tx === 1'b0) begin
                f = cyc; ok = 1'b1; risen = 1'b0; rise = 0; lv = 10'b0;
                for (int i = 0; i < 10; i++) begin
                    repeat ((i == 0) ? HALF : BIT) begin
                        @(negedge clk);
                        if (rst) ok = 1'b0;
                        if (!risen && ser.tx === 1'b1) begin
                            risen = 1'b1;
                            rise = cyc;
                        end
                    end
                    lv[i] = ser.tx;
                end
                if (ok) begin
                    mon_fall.push_back(f);
                    mon_low.push_back(rise - f);
                    mon_lv.push_back(lv);
                    frames_total++;
                end else begin
                    aborted++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int e0);
        e0 = cyc;
        ser.rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            ser.rx = d[i];
            idle(BIT);
        end
        ser.rx = stop;
        idle(BIT);
        ser.rx = 1'b1;
    endtask

    task automatic wait_frames(input int n, output bit timed_out);
        int k = 0;
        while (frames_total < n && k < 20 * BIT) begin
            @(posedge clk);
            k++;
        end
        #1;
        timed_out = (frames_total < n);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ser.rx = 1'b1;
        idle(5);
        n_cmp++;
        if (ser.tx !== 1'b1) begin
            n_bad++; $display("FAIL reset_tx_high: got %b want 1", ser.tx);
        end
        rst = 1'b0;
        idle(4);
        n_cmp++;
        if (ser.tx !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_tx_idle: got %b want 1", ser.tx);
        end
    endtask

    task automatic test_echo_55;
        int e0; int f; int lo; logic [9:0] lv; bit to; int lows = 0;
        send_frame(8'h55, 1'b1, e0);
        wait_frames(1, to);
        n_cmp++;
        if (to) begin
            n_bad++; $display("FAIL echo55_timeout: got %0d frames want 1", frames_total);
        end else begin
            f = mon_fall.pop_front(); lo = mon_low.pop_front(); lv = mon_lv.pop_front();
            n_cmp++;
            if (f - e0 < STOP_CTR || f - e0 > STOP_CTR + 3) begin
                n_bad++; $display("FAIL echo55_latency: got %0d want %0d..%0d", f - e0, STOP_CTR, STOP_CTR + 3);
            end
            n_cmp++;
            if (lv !== 10'b1010101010) begin
                n_bad++; $display("FAIL echo55_bits: got %b want 1010101010", lv);
            end
            n_cmp++;
            if (lo !== BIT) begin
                n_bad++; $display("FAIL echo55_start_len: got %0d want %0d", lo, BIT);
            end
        end
        for (int i = 0; i < 3 * BIT; i++) begin
            idle(1);
            if (ser.tx !== 1'b1) lows++;
        end
        n_cmp++;
        if (lows != 0) begin
            n_bad++; $display("FAIL echo55_idle_after: got %0d low cycles want 0", lows);
        end
    endtask

    task automatic test_echo_03;
        int e0; int f; int lo; logic [9:0] lv; bit to;
        send_frame(8'h03, 1'b1, e0);
        wait_frames(2, to);
        n_cmp++;
        if (to) begin
            n_bad++; $display("FAIL echo03_timeout: got %0d frames want 2", frames_total);
        end else begin
            f = mon_fall.pop_front(); lo = mon_low.pop_front(); lv = mon_lv.pop_front();
            n_cmp++;
            if (lv !== 10'b1000000110) begin
                n_bad++; $display("FAIL echo03_bits: got %b want 1000000110", lv);
            end
            n_cmp++;
            if (lo !== BIT) begin
                n_bad++; $display("FAIL echo03_start_len: got %0d want %0d", lo, BIT);
            end
            n_cmp++;
            if (f - e0 < STOP_CTR || f - e0 > STOP_CTR + 3) begin
                n_bad++; $display("FAIL echo03_latency: got %0d want %0d..%0d", f - e0, STOP_CTR, STOP_CTR + 3);
            end
        end
        idle(3 * BIT);
        n_cmp++;
        if (frames_total !== 2) begin
            n_bad++; $display("FAIL echo03_frame_count: got %0d want 2", frames_total);
        end
    endtask

    task automatic test_back_to_back;
        int e1; int e2; int f1; int f2; int lo1; int lo2; logic [9:0] lv1; logic [9:0] lv2; bit to;
        int base = frames_total;
        send_frame(8'h00, 1'b1, e1);
        send_frame(8'hFF, 1'b1, e2);
        wait_frames(base + 2, to);
        n_cmp++;
        if (to) begin
            n_bad++; $display("FAIL b2b_timeout: got %0d frames want %0d", frames_total, base + 2);
        end else begin
            f1 = mon_fall.pop_front(); lo1 = mon_low.pop_front(); lv1 = mon_lv.pop_front();
            f2 = mon_fall.pop_front(); lo2 = mon_low.pop_front(); lv2 = mon_lv.pop_front();
            n_cmp++;
            if (lv1 !== 10'b1000000000) begin
                n_bad++; $display("FAIL b2b_first_bits: got %b want 1000000000", lv1);
            end
            n_cmp++;
            if (lv2 !== 10'b1111111110) begin
                n_bad++; $display("FAIL b2b_second_bits: got %b want 1111111110", lv2);
            end
            n_cmp++;
            if (lo1 !== 9 * BIT || lo2 !== BIT) begin
                n_bad++; $display("FAIL b2b_low_runs: got %0d,%0d want %0d,%0d", lo1, lo2, 9 * BIT, BIT);
            end
            n_cmp++;
            if (f2 - f1 < 10 * BIT || f2 - f1 > 10 * BIT + 1) begin
                n_bad++; $display("FAIL b2b_spacing: got %0d want %0d..%0d", f2 - f1, 10 * BIT, 10 * BIT + 1);
            end
        end
        idle(3 * BIT);
        n_cmp++;
        if (frames_total !== base + 2) begin
            n_bad++; $display("FAIL b2b_frame_count: got %0d want %0d", frames_total, base + 2);
        end
    endtask

    task automatic test_framing_error;
        int ea; int e0; int f; logic [9:0] lv; bit to;
        int base = frames_total;
        send_frame(8'hA5, 1'b0, ea);
        idle(2 * BIT);
        send_frame(8'h3C, 1'b1, e0);
        wait_frames(base + 1, to);
        n_cmp++;
        if (to) begin
            n_bad++; $display("FAIL ferr_timeout: got %0d frames want %0d", frames_total, base + 1);
        end else begin
            f = mon_fall.pop_front(); lv = mon_lv.pop_front(); void'(mon_low.pop_front());
            n_cmp++;
            if (lv !== 10'b1001111000) begin
                n_bad++; $display("FAIL ferr_echo3c_bits: got %b want 1001111000", lv);
            end
            n_cmp++;
            if (f - e0 < STOP_CTR || f - e0 > STOP_CTR + 3) begin
                n_bad++; $display("FAIL ferr_echo3c_latency: got %0d want %0d..%0d", f - e0, STOP_CTR, STOP_CTR + 3);
            end
        end
        idle(3 * BIT);
        n_cmp++;
        if (frames_total !== base + 1) begin
            n_bad++; $display("FAIL ferr_frame_count: got %0d want %0d", frames_total, base + 1);
        end
    endtask

    task automatic test_glitch;
        int e0; int lo; logic [9:0] lv; bit to;
        int base = frames_total;
        ser.rx = 1'b0;
        idle(HALF - 10);
        ser.rx = 1'b1;
        idle(12 * BIT);
        n_cmp++;
        if (frames_total !== base) begin
            n_bad++; $display("FAIL glitch_no_frame: got %0d frames want %0d", frames_total, base);
        end
        send_frame(8'h81, 1'b1, e0);
        wait_frames(base + 1, to);
        n_cmp++;
        if (to) begin
            n_bad++; $display("FAIL glitch_echo81_timeout: got %0d frames want %0d", frames_total, base + 1);
        end else begin
            void'(mon_fall.pop_front()); lo = mon_low.pop_front(); lv = mon_lv.pop_front();
            n_cmp++;
            if (lv !== 10'b1100000010) begin
                n_bad++; $display("FAIL glitch_echo81_bits: got %b want 1100000010", lv);
            end
            n_cmp++;
            if (lo !== BIT) begin
                n_bad++; $display("FAIL glitch_echo81_start_len: got %0d want %0d", lo, BIT);
            end
        end
    endtask

    task automatic test_reset_midframe;
        int e0; int lo; logic [9:0] lv; bit to; int lows = 0;
        int base = frames_total;
        int ab = aborted;
        send_frame(8'h00, 1'b1, e0);
        idle(3 * BIT);
        n_cmp++;
        if (ser.tx !== 1'b0) begin
            n_bad++; $display("FAIL midframe_tx_low: got %b want 0", ser.tx);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (ser.tx !== 1'b1) begin
            n_bad++; $display("FAIL async_reset_tx: got %b want 1", ser.tx);
        end
        idle(3);
        rst = 1'b0;
        for (int i = 0; i < 12 * BIT; i++) begin
            idle(1);
            if (ser.tx !== 1'b1) lows++;
        end
        n_cmp++;
        if (lows != 0 || frames_total !== base) begin
            n_bad++; $display("FAIL reset_stays_idle: got %0d low cycles, %0d frames want 0, %0d", lows, frames_total, base);
        end
        n_cmp++;
        if (aborted !== ab + 1) begin
            n_bad++; $display("FAIL reset_abandoned_frame: got %0d aborted want %0d", aborted, ab + 1);
        end
        send_frame(8'h5A, 1'b1, e0);
        wait_frames(base + 1, to);
        n_cmp++;
        if (to) begin
            n_bad++; $display("FAIL echo5a_timeout: got %0d frames want %0d", frames_total, base + 1);
        end else begin
            void'(mon_fall.pop_front()); lo = mon_low.pop_front(); lv = mon_lv.pop_front();
            n_cmp++;
            if (lv !== 10'b1010110100) begin
                n_bad++; $display("FAIL echo5a_bits: got %b want 1010110100", lv);
            end
            n_cmp++;
            if (lo !== 2 * BIT) begin
                n_bad++; $display("FAIL echo5a_start_len: got %0d want %0d", lo, 2 * BIT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_echo_55();
        test_echo_03();
        test_back_to_back();
        test_framing_error();
        test_glitch();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
